mul4_stream_sequencer: RTL and testbench

Sequential front end for the team's combinational 4x4 truncating multiplier. It accepts a stream of 4-bit operands over a valid/ready handshake and pairs them (first beat = A, second beat = B). It holds each pair stable on the multiplier's inputs for a programmable settling window, then captures the 4-bit product and presents it downstream over a second valid/ready handshake. The block sits directly upstream of the multiplier: it drives the multiplier's `a`/`b` inputs and samples its `out`.

---
 rtl/mul4_pkg.sv | 14 +
 rtl/mul4_nor.sv | 52 +++++
 rtl/mul4_stream_sequencer.sv | 93 +++++++++
 tb/tb_mul4_stream_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul4_pkg.sv
// rtl/mul4_pkg.sv - shared types and widths for the 4-bit multiplier front end
package mul4_pkg;

   localparam int MUL_W      = 4;
   localparam int PAIR_CNT_W = 8;

   typedef enum logic [1:0] {
      GET_A  = 2'd0,
      GET_B  = 2'd1,
      SETTLE = 2'd2,
      OUT    = 2'd3
   } state_t;

endpackage

// File: rtl/mul4_nor.sv
// rtl/mul4_nor.sv - combinational 4x4 truncating multiplier built from NOR gates
//   a, b : operands
//   out  : low 4 bits of a*b
module mul4_nor (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] out
);

   function automatic logic f_nor(input logic x, input logic y);
      return ~(x | y);
   endfunction

   function automatic logic f_not(input logic x);
      return f_nor(x, x);
   endfunction

   function automatic logic f_or(input logic x, input logic y);
      return f_not(f_nor(x, y));
   endfunction

   function automatic logic f_and(input logic x, input logic y);
      return f_nor(f_not(x), f_not(y));
   endfunction

   function automatic logic f_xor(input logic x, input logic y);
      return f_nor(f_nor(x, y), f_and(x, y));
   endfunction

   logic w_c1;
   logic w_s2a;
   logic w_x2;
   logic w_ca;
   logic w_cb;

   // Column 2 sums three partial products plus the column-1 carry; only the
   // parity of the carries into column 3 matters because bit 4 is dropped.
   assign w_c1  = f_and(f_and(a[1], b[0]), f_and(a[0], b[1]));
   assign w_x2  = f_xor(f_and(a[2], b[0]), f_and(a[1], b[1]));
   assign w_s2a = f_xor(w_x2, f_and(a[0], b[2]));
   assign w_ca  = f_or(f_and(f_and(a[2], b[0]), f_and(a[1], b[1])),
                       f_and(f_and(a[0], b[2]), w_x2));
   assign w_cb  = f_and(w_s2a, w_c1);

   assign out[0] = f_and(a[0], b[0]);
   assign out[1] = f_xor(f_and(a[1], b[0]), f_and(a[0], b[1]));
   assign out[2] = f_xor(w_s2a, w_c1);
   assign out[3] = f_xor(f_xor(f_xor(f_and(a[3], b[0]), f_and(a[2], b[1])),
                               f_xor(f_and(a[1], b[2]), f_and(a[0], b[3]))),
                         f_xor(w_ca, w_cb));

endmodule

// File: rtl/mul4_stream_sequencer.sv
// rtl/mul4_stream_sequencer.sv - pairs operand beats, holds them on the multiplier, returns the product
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/valid/ready : operand stream, first beat A, second beat B
//   mul_a, mul_b        : registered operands to the external multiplier
//   mul_prod            : product from the external multiplier
//   out_data/valid/ready: product stream
//   busy                : pair in progress
//   pair_cnt            : products delivered, modulo 256
module mul4_stream_sequencer
   import mul4_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [MUL_W-1:0]      in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [MUL_W-1:0]      mul_a,
   output logic [MUL_W-1:0]      mul_b,
   input  logic [MUL_W-1:0]      mul_prod,
   output logic [MUL_W-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic [PAIR_CNT_W-1:0] pair_cnt
);

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_t                r_state;
   logic [MUL_W-1:0]      r_mul_a;
   logic [MUL_W-1:0]      r_mul_b;
   logic [MUL_W-1:0]      r_out_data;
   logic                  r_out_valid;
   logic [3:0]            r_wait_cnt;
   logic [PAIR_CNT_W-1:0] r_pair_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= GET_A;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_wait_cnt  <= '0;
         r_pair_cnt  <= '0;
      end else begin
         case (r_state)
            GET_A: begin
               if (in_valid) begin
                  r_mul_a <= in_data;
                  r_state <= GET_B;
               end
            end
            GET_B: begin
               if (in_valid) begin
                  r_mul_b    <= in_data;
                  r_wait_cnt <= '0;
                  r_state    <= SETTLE;
               end
            end
            SETTLE: begin
               r_wait_cnt <= r_wait_cnt + 4'd1;
               // Operands have been stable for WAIT_CYCLES edges when this fires.
               if (r_wait_cnt == WAIT_LAST) begin
                  r_out_data  <= mul_prod;
                  r_out_valid <= 1'b1;
                  r_state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_pair_cnt  <= r_pair_cnt + 8'd1;
                  r_state     <= GET_A;
               end
            end
            default: r_state <= GET_A;
         endcase
      end
   end

   // Ready depends on state alone so upstream never sees a valid-to-ready path.
   assign in_ready  = (r_state == GET_A) || (r_state == GET_B);
   assign busy      = (r_state != GET_A);
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign pair_cnt  = r_pair_cnt;

endmodule

// File: tb/tb_mul4_stream_sequencer.sv
// tb/tb_mul4_stream_sequencer.sv - bench for mul4_stream_sequencer with WAIT_CYCLES 1 and 3
module tb_mul4_stream_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [1:0][3:0] in_data;
   logic [1:0][3:0] mul_a;
   logic [1:0][3:0] mul_b;
   logic [1:0][3:0] mul_prod;
   logic [1:0][3:0] out_data;
   logic [1:0][7:0] pair_cnt;
   logic [1:0]      in_valid;
   logic [1:0]      in_ready;
   logic [1:0]      out_valid;
   logic [1:0]      out_ready;
   logic [1:0]      busy;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int exp_cnt [2];
   int wv      [2];

   always @(posedge clk) cyc <= cyc + 1;

   mul4_stream_sequencer #(.WAIT_CYCLES(1)) u_seq_w1 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_prod(mul_prod[0]),
      .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .busy(busy[0]), .pair_cnt(pair_cnt[0])
   );
   mul4_nor u_mul_w1 (.a(mul_a[0]), .b(mul_b[0]), .out(mul_prod[0]));

   mul4_stream_sequencer #(.WAIT_CYCLES(3)) u_seq_w3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_prod(mul_prod[1]),
      .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .busy(busy[1]), .pair_cnt(pair_cnt[1])
   );
   mul4_nor u_mul_w3 (.a(mul_a[1]), .b(mul_b[1]), .out(mul_prod[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input int k);
      check("rst_in_ready",  32'(in_ready[k]),  32'd1);
      check("rst_mul_a",     32'(mul_a[k]),     32'd0);
      check("rst_mul_b",     32'(mul_b[k]),     32'd0);
      check("rst_out_data",  32'(out_data[k]),  32'd0);
      check("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check("rst_busy",      32'(busy[k]),      32'd0);
      check("rst_pair_cnt",  32'(pair_cnt[k]),  32'd0);
   endtask

   // Present one beat after `gap` idle cycles; returns the cycle index of the accepting edge.
   task automatic send_beat(input int k, input logic [3:0] d, input int gap, output int t_acc);
      int n;
      in_valid[k] = 1'b0;
      repeat (gap) tick();
      in_data[k]  = d;
      in_valid[k] = 1'b1;
      n = 0;
      while (!in_ready[k] && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_timeout", 32'(n < 50), 32'd1);
      tick();
      t_acc       = cyc;
      in_valid[k] = 1'b0;
      in_data[k]  = 4'($urandom);
   endtask

   // One full transaction checked against plain arithmetic: product = (a*b) mod 16,
   // latency from B accept = WAIT_CYCLES, out_valid held through `stall` cycles.
   task automatic do_pair(input int k, input logic [3:0] a, input logic [3:0] b,
                          input int gap_a, input int gap_b, input int stall,
                          input logic rdy_pre, output int t_a);
      int t_b;
      int n;
      int exp_p;
      exp_p = (int'(a) * int'(b)) % 16;
      out_ready[k] = rdy_pre;
      send_beat(k, a, gap_a, t_a);
      check("busy_after_a", 32'(busy[k]), 32'd1);
      check("mul_a_load",   32'(mul_a[k]), 32'(a));
      send_beat(k, b, gap_b, t_b);
      check("mul_b_load",   32'(mul_b[k]), 32'(b));
      check("mul_a_kept",   32'(mul_a[k]), 32'(a));
      n = 0;
      while (!out_valid[k] && n < 40) begin
         check("in_ready_settle", 32'(in_ready[k]), 32'd0);
         tick();
         n++;
      end
      check("latency",  32'(cyc - t_b), 32'(wv[k]));
      check("out_data", 32'(out_data[k]), 32'(exp_p));
      out_ready[k] = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         check("stall_valid",    32'(out_valid[k]), 32'd1);
         check("stall_data",     32'(out_data[k]),  32'(exp_p));
         check("stall_in_ready", 32'(in_ready[k]),  32'd0);
      end
      out_ready[k] = 1'b1;
      tick();
      exp_cnt[k] = (exp_cnt[k] + 1) % 256;
      check("post_valid",    32'(out_valid[k]), 32'd0);
      check("post_in_ready", 32'(in_ready[k]),  32'd1);
      check("post_busy",     32'(busy[k]),      32'd0);
      check("pair_cnt",      32'(pair_cnt[k]),  32'(exp_cnt[k]));
      check("mul_a_hold",    32'(mul_a[k]),     32'(a));
      check("mul_b_hold",    32'(mul_b[k]),     32'(b));
      check("out_data_hold", 32'(out_data[k]),  32'(exp_p));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t_a;
      int t_prev;
      int t_dummy;
      wv[0] = 1;
      wv[1] = 3;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = '0;
      repeat (3) tick();
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      tick();

      // Directed products on WAIT_CYCLES=1.
      do_pair(0, 4'd3,  4'd5,  0, 0, 0,  1'b1, t_a);
      check("p3x5", 32'(out_data[0]), 32'hF);
      do_pair(0, 4'd7,  4'd3,  0, 0, 0,  1'b1, t_a);
      check("p7x3", 32'(out_data[0]), 32'h5);
      do_pair(0, 4'd15, 4'd15, 0, 0, 0,  1'b0, t_a);
      check("p15x15", 32'(out_data[0]), 32'h1);
      do_pair(0, 4'd2,  4'd6,  0, 0, 10, 1'b0, t_a);
      check("p2x6", 32'(out_data[0]), 32'hC);

      // Reset while in SETTLE discards the pair.
      send_beat(0, 4'd4, 0, t_dummy);
      send_beat(0, 4'd4, 0, t_dummy);
      check("settle_busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      check_reset(0);
      repeat (3) begin
         tick();
         check("no_output_after_rst", 32'(out_valid[0]), 32'd0);
      end
      do_pair(0, 4'd2, 4'd3, 0, 0, 0, 1'b1, t_a);
      check("p2x3", 32'(out_data[0]), 32'h6);

      // WAIT_CYCLES=3 with gaps on in_valid and random stalls.
      for (int i = 0; i < 20; i++) begin
         do_pair(1, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom), t_a);
      end

      // Random gaps on WAIT_CYCLES=1.
      for (int i = 0; i < 15; i++) begin
         do_pair(0, 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 1'($urandom), t_a);
      end

      // 256 back-to-back pairs: pair_cnt wraps and the period is WAIT_CYCLES+3.
      t_prev = 0;
      for (int i = 0; i < 256; i++) begin
         do_pair(0, 4'($urandom), 4'($urandom), 0, 0, 0, 1'b1, t_a);
         if (i > 0) check("period", 32'(t_a - t_prev), 32'(wv[0] + 3));
         t_prev = t_a;
      end
      check("wrap_cnt", 32'(pair_cnt[0]), 32'((16 + 256) % 256));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
